cpu_sequencer: RTL and testbench

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

---
 rtl/cpu_pkg.sv | 27 ++
 rtl/cpu_pc_unit.sv | 31 +++
 rtl/cpu_sequencer.sv | 81 ++++++++
 tb/tb_cpu_sequencer.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared sequencer state encoding, opcode constants and instruction field positions.
package cpu_pkg;

    localparam int PC_W       = 6;
    localparam int CNT_W      = 16;
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 28;
    localparam int TARGET_MSB = 5;
    localparam int TARGET_LSB = 0;

    localparam logic [3:0] HALT_OP_DEF = 4'hF;
    localparam logic [3:0] BEQZ_OP_DEF = 4'hE;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return &v ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/cpu_pc_unit.sv
// cpu_pc_unit: program counter register with reset-load, increment and even-aligned branch.
module cpu_pc_unit
    import cpu_pkg::*;
#(
    parameter logic [PC_W-1:0] PC_RESET = 6'd0,
    parameter logic [PC_W-1:0] PC_STEP  = 6'd2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            adv,
    input  logic            take_branch,
    input  logic [PC_W-1:0] target,
    output logic [PC_W-1:0] pc
);

    logic [PC_W-1:0] pc_nxt;

    // branch targets are forced even; the increment wraps naturally at 6 bits
    always_comb begin
        pc_nxt = load ? PC_RESET :
                 adv  ? (take_branch ? (target & ~6'd1) : pc + PC_STEP) :
                 pc;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pc <= PC_RESET;
        else        pc <= pc_nxt;
    end

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: fetch/decode/exec/writeback sequencer with stall, halt and BEQZ branching.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter logic [PC_W-1:0] PC_RESET = 6'd0,
    parameter logic [PC_W-1:0] PC_STEP  = 6'd2,
    parameter logic [3:0]      HALT_OP  = HALT_OP_DEF,
    parameter logic [3:0]      BEQZ_OP  = BEQZ_OP_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stall,
    input  logic [3:0]       opcode,
    input  logic [PC_W-1:0]  branch_target,
    input  logic             zero,
    output logic [PC_W-1:0]  pc,
    output logic             fetch_en,
    output logic             decode_en,
    output logic             exec_en,
    output logic             wb_en,
    output logic             busy,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count
);

    state_t     state, state_nxt;
    logic [3:0] op_q;
    logic       zero_q;
    logic       load;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, HALT: if (start)  state_nxt = FETCH;
            FETCH:      if (!stall) state_nxt = DECODE;
            DECODE:     if (!stall) state_nxt = (opcode == HALT_OP) ? HALT : EXEC;
            EXEC:       if (!stall) state_nxt = WB;
            WB:         if (!stall) state_nxt = FETCH;
            default:    state_nxt = IDLE;
        endcase
        fetch_en  = (state == FETCH)  && !stall;
        decode_en = (state == DECODE) && !stall;
        exec_en   = (state == EXEC)   && !stall;
        wb_en     = (state == WB)     && !stall;
        busy      = state inside {FETCH, DECODE, EXEC, WB};
        halted    = state == HALT;
        load      = (state == IDLE || state == HALT) && start;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q        <= '0;
            zero_q      <= 1'b0;
            instr_count <= '0;
        end else begin
            if (decode_en) op_q <= opcode;
            if (exec_en)   zero_q <= zero;
            instr_count <= load ? '0 : wb_en ? sat_inc(instr_count) : instr_count;
        end
    end

    cpu_pc_unit #(
        .PC_RESET(PC_RESET),
        .PC_STEP (PC_STEP)
    ) u_pc (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .adv        (wb_en),
        .take_branch(op_q == BEQZ_OP && zero_q),
        .target     (branch_target),
        .pc         (pc)
    );

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed self-checking bench for cpu_sequencer.
module tb_cpu_sequencer;

    logic        clk = 1'b0;
    logic        reset, start, stall, zero;
    logic [3:0]  opcode;
    logic [5:0]  branch_target, pc;
    logic        fetch_en, decode_en, exec_en, wb_en, busy, halted;
    logic [15:0] instr_count;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    cpu_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .stall        (stall),
        .opcode       (opcode),
        .branch_target(branch_target),
        .zero         (zero),
        .pc           (pc),
        .fetch_en     (fetch_en),
        .decode_en    (decode_en),
        .exec_en      (exec_en),
        .wb_en        (wb_en),
        .busy         (busy),
        .halted       (halted),
        .instr_count  (instr_count)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // flags = {fetch_en, decode_en, exec_en, wb_en, busy, halted}
    task automatic chk_st(input string tag, input logic [5:0] flags, input logic [5:0] p, input logic [15:0] c);
        chk({tag, "_flags"}, {26'd0, fetch_en, decode_en, exec_en, wb_en, busy, halted}, {26'd0, flags});
        chk({tag, "_pc"}, {26'd0, pc}, {26'd0, p});
        chk({tag, "_cnt"}, {16'd0, instr_count}, {16'd0, c});
    endtask

    task automatic instr(input logic [3:0] op, input logic z, input logic [5:0] bt,
                         input logic [5:0] p, input logic [15:0] c);
        opcode = op; zero = z; branch_target = bt;
        chk_st("fetch", 6'b100010, p, c);
        cyc();
        chk_st("decode", 6'b010010, p, c);
        cyc();
        chk_st("exec", 6'b001010, p, c);
        cyc();
        chk_st("wb", 6'b000110, p, c);
        cyc();
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; stall = 1'b0; zero = 1'b0;
        opcode = 4'h0; branch_target = 6'd0;
        #3;
        chk_st("reset", 6'b000000, 6'd0, 16'd0);
        cyc(); cyc();
        reset = 1'b1;
        cyc();
        chk_st("idle_wait", 6'b000000, 6'd0, 16'd0);
        start = 1'b1;
        cyc();
        start = 1'b0;
        instr(4'h0, 1'b0, 6'd0, 6'd0, 16'd0);
        instr(4'h0, 1'b0, 6'd0, 6'd2, 16'd1);
        instr(4'h0, 1'b0, 6'd0, 6'd4, 16'd2);
        chk_st("seq3", 6'b100010, 6'd6, 16'd3);
        // BEQZ taken (21 -> 20), not taken, then a jump to 62 and wrap to 0
        instr(4'hE, 1'b1, 6'd21, 6'd6, 16'd3);
        chk_st("beqz_taken", 6'b100010, 6'd20, 16'd4);
        instr(4'hE, 1'b0, 6'd21, 6'd20, 16'd4);
        chk_st("beqz_not", 6'b100010, 6'd22, 16'd5);
        instr(4'hE, 1'b1, 6'd62, 6'd22, 16'd5);
        instr(4'h0, 1'b1, 6'd21, 6'd62, 16'd6);
        chk_st("wrap", 6'b100010, 6'd0, 16'd7);
        // stall three cycles in EXEC
        opcode = 4'h0; zero = 1'b0;
        cyc();
        cyc();
        stall = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk_st("stall_exec", 6'b000010, 6'd0, 16'd7);
            cyc();
        end
        stall = 1'b0;
        #1;
        chk_st("stall_release", 6'b001010, 6'd0, 16'd7);
        cyc();
        chk_st("stall_wb", 6'b000110, 6'd0, 16'd7);
        cyc();
        instr(4'h0, 1'b0, 6'd0, 6'd2, 16'd8);
        instr(4'h0, 1'b0, 6'd0, 6'd4, 16'd9);
        instr(4'h0, 1'b0, 6'd0, 6'd6, 16'd10);
        // halt at pc 8
        opcode = 4'hF;
        chk_st("halt_fetch", 6'b100010, 6'd8, 16'd11);
        cyc();
        chk_st("halt_decode", 6'b010010, 6'd8, 16'd11);
        cyc();
        chk_st("halted", 6'b000001, 6'd8, 16'd11);
        opcode = 4'h0;
        stall = 1'b1;
        cyc();
        chk_st("halt_hold", 6'b000001, 6'd8, 16'd11);
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk_st("restart_stall", 6'b000010, 6'd0, 16'd0);
        stall = 1'b0;
        #1;
        instr(4'h0, 1'b0, 6'd0, 6'd0, 16'd0);
        chk_st("pre_reset", 6'b100010, 6'd2, 16'd1);
        cyc();
        chk_st("pre_reset_dec", 6'b010010, 6'd2, 16'd1);
        #2;
        reset = 1'b0;
        #1;
        chk_st("async_reset", 6'b000000, 6'd0, 16'd0);
        cyc();
        chk_st("reset_hold", 6'b000000, 6'd0, 16'd0);
        reset = 1'b1;
        cyc();
        cyc();
        chk_st("post_reset_idle", 6'b000000, 6'd0, 16'd0);
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk_st("post_reset_fetch", 6'b100010, 6'd0, 16'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
